instruction_fetch: RTL

- Fetch stage directly upstream of `instruction_memory` (10-bit byte address in, 32-bit instruction out, combinational read).
- Holds the program counter and drives the memory address.
- Captures each returned instruction into an IF/ID output register and hands it to decode with a valid/ready handshake.
- Supports stall (decode back-pressure), enable, and redirect (branch/jump) with flush.

---
 rtl/instruction_fetch.sv | 86 ++++++++
 1 files changed

// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, drives instruction_memory combinationally and
// registers each returned instruction into an IF/ID register handed to decode.
module instruction_fetch #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          ADDR_WIDTH = 10,
  parameter logic [31:0] NOP_INSTR  = 32'h0000_0013
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  fetch_en,
  output logic [ADDR_WIDTH-1:0] imem_address,
  input  logic [31:0]           imem_instruction,
  input  logic                  redirect_valid,
  input  logic [31:0]           redirect_pc,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [31:0]           out_instruction,
  output logic [31:0]           out_pc,
  output logic [31:0]           out_pc_plus4,
  output logic [15:0]           fetched_count
);

  logic [31:0] pc_p0;
  logic        vld_p1;
  logic [31:0] instr_p1;
  logic [31:0] pc_p1;
  logic [15:0] cnt_p1;
  logic        accept;
  logic        load;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    sat_inc16 = (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  function automatic logic [31:0] align_word(input logic [31:0] a);
    align_word = {a[31:2], 2'b00};
  endfunction

  assign accept = vld_p1 & out_ready;
  assign load   = fetch_en & ~redirect_valid & (~vld_p1 | out_ready);

  // Stage p0: program counter and memory address (zero-latency read)
  assign imem_address = pc_p0[ADDR_WIDTH-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_p0 <= RESET_PC;
    end else if (redirect_valid) begin
      pc_p0 <= align_word(redirect_pc);
    end else if (load) begin
      pc_p0 <= pc_p0 + 32'd4;
    end
  end

  // Stage p1: IF/ID output register; a redirect flushes whatever is held
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1   <= 1'b0;
      instr_p1 <= NOP_INSTR;
      pc_p1    <= RESET_PC;
    end else if (redirect_valid) begin
      vld_p1 <= 1'b0;
    end else if (load) begin
      vld_p1   <= 1'b1;
      instr_p1 <= imem_instruction;
      pc_p1    <= pc_p0;
    end else if (accept) begin
      vld_p1 <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_p1 <= 16'd0;
    end else if (accept && !redirect_valid) begin
      cnt_p1 <= sat_inc16(cnt_p1);
    end
  end

  assign out_valid       = vld_p1;
  assign out_instruction = instr_p1;
  assign out_pc          = pc_p1;
  assign out_pc_plus4    = pc_p1 + 32'd4;
  assign fetched_count   = cnt_p1;

endmodule
